// File: rtl/puntuacion_carriles_if.sv
// ----------------------------------------------------------------------------
// puntuacion_carriles_if: lane inputs and score/HUD outputs of the drum scorer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface puntuacion_carriles_if #(
  parameter int LANES   = 5,
  parameter int POS_W   = 10,
  parameter int SCORE_W = 13
);
  logic                     start;
  logic [POS_W-1:0]         hit_line;
  logic [LANES*POS_W-1:0]   note_pos;
  logic [LANES-1:0]         note_valid;
  logic [LANES-1:0]         key;
  logic [SCORE_W-1:0]       puntuacion;
  logic [7:0]               combo;
  logic [2:0]               multiplicador;
  logic [3:0]               fallos;
  logic                     perdio;
  logic [LANES-1:0]         hit_pulse;
  logic [LANES-1:0]         miss_pulse;

  modport master (
    output start, hit_line, note_pos, note_valid, key,
    input  puntuacion, combo, multiplicador, fallos, perdio, hit_pulse, miss_pulse
  );

  modport slave (
    input  start, hit_line, note_pos, note_valid, key,
    output puntuacion, combo, multiplicador, fallos, perdio, hit_pulse, miss_pulse
  );
endinterface

`default_nettype wire

// File: rtl/puntuacion_carriles.sv
// ----------------------------------------------------------------------------
// puntuacion_carriles: per-lane hit/miss judging, combo score and game-over FSM.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module puntuacion_carriles #(
  parameter int LANES       = 5,
  parameter int POS_W       = 10,
  parameter int SCORE_W     = 13,
  parameter int HIT_WIN     = 8,
  parameter int MISS_OFFSET = 64,
  parameter int COMBO_STEP  = 8,
  parameter int MAX_MULT    = 4,
  parameter int MAX_MISSES  = 5
) (
  input  wire logic              clk,
  input  wire logic              reset,
  puntuacion_carriles_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;
  localparam int CW = $clog2(LANES + 1);
  localparam int SW = SCORE_W + CW + 4;

  logic [1:0]         state_q, state_d;
  logic [LANES-1:0]   key_q, done_q, done_d;
  logic [LANES-1:0]   hit_q, miss_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic [3:0]         fallos_q, fallos_d;

  logic [POS_W:0]     lo, hi, mz;
  logic [LANES-1:0]   press, armed, clr, hit_w, bad_w, miss_w;
  logic               play;
  logic [CW-1:0]      n_hit, n_miss;
  logic [8:0]         mult_full;
  logic [2:0]         mult_sat, mult_o;
  logic               perdio_o;
  logic [SW-1:0]      score_sum;
  logic [8:0]         combo_sum;
  logic [4:0]         fallos_sum;

  // Window bounds carry one extra bit so hit_line near the top of range never wraps.
  assign lo = ({1'b0, bus.hit_line} >= (POS_W+1)'(HIT_WIN))
            ? {1'b0, bus.hit_line} - (POS_W+1)'(HIT_WIN) : '0;
  assign hi = {1'b0, bus.hit_line} + (POS_W+1)'(HIT_WIN);
  assign mz = {1'b0, bus.hit_line} + (POS_W+1)'(MISS_OFFSET);

  // A start pulse takes priority: no judging happens in the restart cycle.
  assign play  = (state_q == ST_PLAY) & ~bus.start;
  assign press = bus.key & ~key_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [POS_W:0] pos;
    assign pos       = {1'b0, bus.note_pos[i*POS_W +: POS_W]};
    assign armed[i]  = bus.note_valid[i] & ~done_q[i] & (pos >= lo) & (pos <= hi);
    assign miss_w[i] = play & bus.note_valid[i] & ~done_q[i] & (pos >= mz);
    assign clr[i]    = ~bus.note_valid[i] | (pos < lo);
  end

  assign hit_w = {LANES{play}} & press & armed;
  assign bad_w = {LANES{play}} & press & ~armed;

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      n_hit  = n_hit  + CW'(hit_w[i]);
      n_miss = n_miss + CW'(miss_w[i]);
    end
  end

  assign mult_full = 9'd1 + 9'(combo_q / 8'(COMBO_STEP));
  assign mult_sat  = (mult_full > 9'(MAX_MULT)) ? 3'(MAX_MULT) : mult_full[2:0];

  assign score_sum  = SW'(score_q) + SW'(n_hit) * SW'(mult_sat);
  assign combo_sum  = 9'(combo_q) + 9'(n_hit);
  assign fallos_sum = 5'(fallos_q) + 5'(n_miss);

  always_comb begin
    score_d  = score_q;
    combo_d  = combo_q;
    fallos_d = fallos_q;
    done_d   = (done_q | hit_w | miss_w) & ~clr;
    if (bus.start) begin
      score_d  = '0;
      combo_d  = '0;
      fallos_d = '0;
      done_d   = '0;
    end else if (play) begin
      score_d  = (score_sum > SW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      if ((|miss_w) || (|bad_w))
        combo_d = '0;
      else
        combo_d = (combo_sum > 9'd255) ? 8'hFF : combo_sum[7:0];
      fallos_d = (fallos_sum > 5'd15) ? 4'hF : fallos_sum[3:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.start)
      state_d = ST_PLAY;
    else if (state_q == ST_PLAY && fallos_d >= 4'(MAX_MISSES))
      state_d = ST_OVER;
  end

  // FSM: outputs
  always_comb begin
    mult_o   = mult_sat;
    perdio_o = 1'b0;
    case (state_q)
      ST_IDLE: mult_o   = 3'd0;
      ST_OVER: perdio_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      done_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      score_q  <= '0;
      combo_q  <= '0;
      fallos_q <= '0;
    end else begin
      key_q    <= bus.key;
      done_q   <= done_d;
      hit_q    <= hit_w;
      miss_q   <= miss_w;
      score_q  <= score_d;
      combo_q  <= combo_d;
      fallos_q <= fallos_d;
    end
  end

  assign bus.puntuacion    = score_q;
  assign bus.combo         = combo_q;
  assign bus.multiplicador = mult_o;
  assign bus.fallos        = fallos_q;
  assign bus.perdio        = perdio_o;
  assign bus.hit_pulse     = hit_q;
  assign bus.miss_pulse    = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_puntuacion_carriles.sv
// ----------------------------------------------------------------------------
// tb_puntuacion_carriles: scoreboard bench for the drum scoring block.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_puntuacion_carriles;
  localparam int LANES   = 5;
  localparam int POS_W   = 10;
  localparam int SCORE_W = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  puntuacion_carriles_if #(.LANES(LANES), .POS_W(POS_W), .SCORE_W(SCORE_W)) bus ();

  puntuacion_carriles #(.LANES(LANES), .POS_W(POS_W), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [SCORE_W-1:0] sc;
    logic [7:0]         co;
    logic [2:0]         mu;
    logic [3:0]         fa;
    logic               pe;
    logic [LANES-1:0]   hp;
    logic [LANES-1:0]   mp;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic out_t sample();
    out_t r;
    r.sc = bus.puntuacion;  r.co = bus.combo;  r.mu = bus.multiplicador;
    r.fa = bus.fallos;      r.pe = bus.perdio; r.hp = bus.hit_pulse;
    r.mp = bus.miss_pulse;
    return r;
  endfunction

  function automatic out_t mk(int sc, int co, int mu, int fa, bit pe,
                              logic [LANES-1:0] hp, logic [LANES-1:0] mp);
    out_t r;
    r.sc = SCORE_W'(sc); r.co = 8'(co); r.mu = 3'(mu); r.fa = 4'(fa);
    r.pe = pe; r.hp = hp; r.mp = mp;
    return r;
  endfunction

  task automatic expect_out(string n, out_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int l, logic v, int pos, logic k);
    bus.note_valid[l]              = v;
    bus.note_pos[l*POS_W +: POS_W] = POS_W'(pos);
    bus.key[l]                     = k;
  endtask

  task automatic clear_lanes();
    bus.note_valid = '0;
    bus.note_pos   = '0;
    bus.key        = '0;
  endtask

  task automatic do_hits(int n);
    for (int h = 0; h < n; h++) begin
      set_lane(0, 1'b1, 400, 1'b1);
      tick();
      clear_lanes();
      tick();
    end
  endtask

  task automatic test_reset();
    out_t g, e; string n;
    for (int p = 0; p < 2; p++) begin
      expect_out(p == 0 ? "reset_held" : "reset_released", mk(0, 0, 0, 0, 0, '0, '0));
      tick();
      if (p == 1) reset = 1'b1;
      g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
    end
  endtask

  task automatic test_single_hit();
    out_t g, e; string n;
    for (int c = 0; c < 13; c++) begin
      clear_lanes();
      bus.start = (c == 0);
      if (c == 0)      expect_out("start", mk(0, 0, 1, 0, 0, '0, '0));
      else if (c == 1) begin
        set_lane(0, 1'b1, 405, 1'b1);
        expect_out("single_hit", mk(1, 1, 1, 0, 0, 5'b00001, '0));
      end else if (c < 12) begin
        set_lane(0, 1'b1, 405, 1'b1);
        expect_out("held_key", mk(1, 1, 1, 0, 0, '0, '0));
      end else
        expect_out("release", mk(1, 1, 1, 0, 0, '0, '0));
      tick();
      bus.start = 1'b0;
      g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
    end
  endtask

  task automatic test_window();
    int pos_t[3] = '{392, 408, 409};
    int sc_t[3]  = '{2, 3, 3};
    int co_t[3]  = '{2, 3, 0};
    bit hit_t[3] = '{1'b1, 1'b1, 1'b0};
    out_t g, e; string n;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (p == 0) begin
          set_lane(0, 1'b1, pos_t[k], 1'b1);
          expect_out($sformatf("window_%0d", pos_t[k]),
                     mk(sc_t[k], co_t[k], 1, 0, 0, {4'b0, hit_t[k]}, '0));
        end else begin
          clear_lanes();
          expect_out("window_release", mk(sc_t[k], co_t[k], 1, 0, 0, '0, '0));
        end
        tick();
        g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
      end
    end
  endtask

  task automatic test_multiplier();
    int sc = 0, co = 0, mu;
    out_t g, e; string n;
    for (int h = 0; h <= 40; h++) begin
      for (int p = 0; p < 2; p++) begin
        clear_lanes();
        if (h == 0) begin
          if (p == 1) break;
          bus.start = 1'b1;
          expect_out("mult_start", mk(0, 0, 1, 0, 0, '0, '0));
        end else begin
          if (p == 0) begin
            mu = (1 + co / 8 > 4) ? 4 : 1 + co / 8;
            sc += mu;
            co += 1;
            set_lane(0, 1'b1, 400, 1'b1);
          end
          mu = (1 + co / 8 > 4) ? 4 : 1 + co / 8;
          expect_out($sformatf("mult_hit%0d_p%0d", h, p),
                     mk(sc, co, mu, 0, 0, p == 0 ? 5'b00001 : 5'b0, '0));
        end
        tick();
        bus.start = 1'b0;
        g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
      end
    end
  endtask

  task automatic test_simultaneous();
    out_t g, e; string n;
    clear_lanes();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    do_hits(8);
    for (int p = 0; p < 3; p++) begin
      clear_lanes();
      if (p == 0) expect_out("simul_pre", mk(8, 8, 2, 0, 0, '0, '0));
      if (p == 1) begin
        set_lane(0, 1'b1, 400, 1'b1);
        set_lane(3, 1'b1, 400, 1'b1);
        set_lane(1, 1'b1, 464, 1'b0);
        expect_out("simul_event", mk(12, 0, 1, 1, 0, 5'b01001, 5'b00010));
      end
      if (p == 2) expect_out("simul_after", mk(12, 0, 1, 1, 0, '0, '0));
      if (p > 0) tick();
      g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
    end
  endtask

  task automatic test_game_over();
    out_t g, e; string n;
    for (int c = 0; c < 13; c++) begin
      clear_lanes();
      if (c == 0) begin
        bus.start = 1'b1;
        expect_out("over_start", mk(0, 0, 1, 0, 0, '0, '0));
      end else if (c <= 10) begin
        if (c % 2 == 1) set_lane(2, 1'b1, 464, 1'b0);
        expect_out($sformatf("miss_%0d_p%0d", (c + 1) / 2, (c + 1) % 2),
                   mk(0, 0, 1, (c + 1) / 2, c >= 9, c % 2 == 1 ? 5'b00100 : 5'b0, '0));
        e = exp_q[$]; e.mp = (c % 2 == 1) ? 5'b00100 : 5'b0; e.hp = '0;
        exp_q[$] = e;
      end else if (c == 11) begin
        set_lane(0, 1'b1, 400, 1'b1);
        expect_out("over_press", mk(0, 0, 1, 5, 1, '0, '0));
      end else begin
        bus.start = 1'b1;
        expect_out("over_restart", mk(0, 0, 1, 0, 0, '0, '0));
      end
      tick();
      bus.start = 1'b0;
      g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
    end
  endtask

  task automatic test_reset_midgame();
    out_t g, e; string n;
    do_hits(10);
    for (int p = 0; p < 6; p++) begin
      case (p)
        0: expect_out("mid_pre", mk(12, 10, 2, 0, 0, '0, '0));
        1: begin
          @(negedge clk); #2;
          set_lane(0, 1'b1, 400, 1'b1);
          reset = 1'b0;
          #1;
          expect_out("async_reset", mk(0, 0, 0, 0, 0, '0, '0));
        end
        2: begin
          tick();
          reset = 1'b1;
          clear_lanes();
          tick();
          set_lane(0, 1'b1, 400, 1'b1);
          tick();
          expect_out("idle_press", mk(0, 0, 0, 0, 0, '0, '0));
        end
        3: begin
          bus.start = 1'b1;
          tick();
          bus.start = 1'b0;
          expect_out("held_over_start", mk(0, 0, 1, 0, 0, '0, '0));
        end
        4: begin
          tick();
          expect_out("held_no_score", mk(0, 0, 1, 0, 0, '0, '0));
        end
        default: begin
          clear_lanes();
          tick();
          expect_out("held_release", mk(0, 0, 1, 0, 0, '0, '0));
        end
      endcase
      g = sample(); e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h want %h", n, g, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.hit_line = POS_W'(400);
    clear_lanes();
    test_reset();
    test_single_hit();
    test_window();
    test_multiplier();
    test_simultaneous();
    test_game_over();
    test_reset_midgame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
